// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits). Each bit is decided by a 3-sample majority vote
// around the bit centre. False start bits are rejected. Parity and framing
// errors are reported with a one-cycle completion strobe.
//
// Ports:
//   sys_clk     in   system clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   uart_rxd    in   asynchronous serial line, idle high
//   uart_done   out  one-cycle strobe: frame complete, data and flags valid
//   uart_data   out  received payload (LSB first on the line), held until next strobe
//   parity_err  out  parity mismatch of the last frame (0 when PARITY = 0)
//   frame_err   out  at least one stop bit of the last frame sampled low
//   rx_busy     out  high while a frame is being received
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 27000000,
    parameter int UART_BPS  = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 uart_rxd,
    output logic                 uart_done,
    output logic [DATA_BITS-1:0] uart_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);
    localparam int          BPS_CNT   = CLK_FREQ / UART_BPS;
    localparam int          HALF      = BPS_CNT / 2;
    localparam logic [15:0] CNT_MAX   = 16'(BPS_CNT - 1);
    localparam logic [15:0] SMP_A     = 16'(HALF - 1);
    localparam logic [15:0] SMP_B     = 16'(HALF);
    localparam logic [15:0] SMP_C     = 16'(HALF + 1);
    localparam logic [3:0]  N_DATA    = 4'(DATA_BITS);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic        ODD       = (PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   s0_q, s0_d, s1_q, s1_d;
    logic [15:0]            clk_cnt_q, clk_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [1:0]             samp_q, samp_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_acc_q, perr_acc_d;
    logic                   ferr_acc_q, ferr_acc_d;
    logic                   uart_done_q, uart_done_d;
    logic [DATA_BITS-1:0]   uart_data_q, uart_data_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   rx_busy_q, rx_busy_d;

    logic start_edge, wrap, dec, maj, exp_par;

    // s1 is the older sample: 1 -> 0 between them is a falling edge.
    assign start_edge = s1_q & ~s0_q;
    assign wrap       = (clk_cnt_q == CNT_MAX);
    // Third sample is taken live, so the vote resolves in the HALF+1 cycle.
    assign dec        = (clk_cnt_q == SMP_C);
    assign maj        = (samp_q[1] & samp_q[0]) | (samp_q[1] & s0_q) | (samp_q[0] & s0_q);
    assign exp_par    = (^shift_q) ^ ODD;

    always_comb begin
        state_d      = state_q;
        s0_d         = uart_rxd;
        s1_d         = s0_q;
        clk_cnt_d    = wrap ? 16'd0 : clk_cnt_q + 16'd1;
        bit_cnt_d    = bit_cnt_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        perr_acc_d   = perr_acc_q;
        ferr_acc_d   = ferr_acc_q;
        uart_data_d  = uart_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        if (clk_cnt_q == SMP_A) samp_d[1] = s0_q;
        if (clk_cnt_q == SMP_B) samp_d[0] = s0_q;

        unique case (state_q)
            ST_IDLE: begin
                clk_cnt_d = 16'd0;
                if (start_edge) begin
                    state_d    = ST_START;
                    bit_cnt_d  = 4'd0;
                    perr_acc_d = 1'b0;
                    ferr_acc_d = 1'b0;
                end
            end
            ST_START: begin
                // A high majority at the centre means the edge was noise.
                if (dec && maj)  state_d = ST_IDLE;
                else if (wrap)   state_d = ST_DATA;
            end
            ST_DATA: begin
                if (dec) begin
                    shift_d   = {maj, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                if (wrap && bit_cnt_q == N_DATA) begin
                    bit_cnt_d = 4'd0;
                    state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (dec)  perr_acc_d = maj ^ exp_par;
                if (wrap) state_d    = ST_STOP;
            end
            ST_STOP: begin
                if (dec) begin
                    ferr_acc_d = ferr_acc_q | ~maj;
                    // Leave mid-bit so the next start edge can land in the
                    // second half of the final stop bit.
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d      = ST_DONE;
                        uart_data_d  = shift_q;
                        parity_err_d = perr_acc_q;
                        frame_err_d  = ferr_acc_q | ~maj;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        uart_done_d = (state_d == ST_DONE);
        rx_busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            s0_q         <= 1'b1;
            s1_q         <= 1'b1;
            clk_cnt_q    <= 16'd0;
            bit_cnt_q    <= 4'd0;
            samp_q       <= 2'b00;
            shift_q      <= '0;
            perr_acc_q   <= 1'b0;
            ferr_acc_q   <= 1'b0;
            uart_done_q  <= 1'b0;
            uart_data_q  <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            perr_acc_q   <= perr_acc_d;
            ferr_acc_q   <= ferr_acc_d;
            uart_done_q  <= uart_done_d;
            uart_data_q  <= uart_data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            rx_busy_q    <= rx_busy_d;
        end
    end

    assign uart_done  = uart_done_q;
    assign uart_data  = uart_data_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg. Four receivers with different frame formats share
// clock and reset; each has its own serial line. The frame sender records
// the expected result of every frame (payload, parity/framing error, strobe
// cycle from the latency formula). A negedge monitor checks strobes and held
// outputs against that record every cycle.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    localparam int CLK_FREQ = 27000000;
    localparam int NI       = 4;

    // inst 0: 8N1 @115200, 1: 7E2 @115200, 2: 9O1 @115200, 3: 8N1 @9600
    function automatic int bps_of(input int i);
        return CLK_FREQ / ((i == 3) ? 9600 : 115200);
    endfunction
    function automatic int db_of(input int i);
        case (i) 1: return 7; 2: return 9; default: return 8; endcase
    endfunction
    function automatic int par_of(input int i);
        case (i) 1: return 2; 2: return 1; default: return 0; endcase
    endfunction
    function automatic int sb_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    typedef struct {
        int         due;
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          rxd [NI];
    logic [NI-1:0] done, perr, ferr, busy;
    logic [7:0]    data_a, data_d;
    logic [6:0]    data_b;
    logic [8:0]    data_c;
    logic [8:0]    dat [NI];
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;

    exp_t          expq [NI][$];
    logic [8:0]    last_data [NI];
    logic          last_pe [NI];
    logic          last_fe [NI];
    int            done_cnt [NI];
    int            done_cyc [NI];

    assign dat[0] = {1'b0, data_a};
    assign dat[1] = {2'b00, data_b};
    assign dat[2] = data_c;
    assign dat[3] = {1'b0, data_d};

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .UART_BPS(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd[0]), .uart_done(done[0]),
        .uart_data(data_a), .parity_err(perr[0]), .frame_err(ferr[0]), .rx_busy(busy[0]));
    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .UART_BPS(115200), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd[1]), .uart_done(done[1]),
        .uart_data(data_b), .parity_err(perr[1]), .frame_err(ferr[1]), .rx_busy(busy[1]));
    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .UART_BPS(115200), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u_c (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd[2]), .uart_done(done[2]),
        .uart_data(data_c), .parity_err(perr[2]), .frame_err(ferr[2]), .rx_busy(busy[2]));
    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .UART_BPS(9600), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_d (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd[3]), .uart_done(done[3]),
        .uart_data(data_d), .parity_err(perr[3]), .frame_err(ferr[3]), .rx_busy(busy[3]));

    task automatic chk(input string nm, input int inst, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", nm, inst, cyc, act, exp);
        end
    endtask

    // Drives one frame on line i. The parity bit is chosen from the ones count
    // of the payload, optionally inverted; all stop bits take ~stop0.
    // last_len > 0 shortens/lengthens the final stop bit; spike_bit >= 0 puts
    // a one-cycle high pulse at the centre of that data bit.
    task automatic send_frame(input int i, input logic [8:0] d, input bit flip_par, input bit stop0,
                              input int last_len, input int spike_bit, input bit expect_done,
                              output int fall);
        int b, h, n, p, s, nb, len;
        logic bits [16];
        logic [8:0] dm;
        exp_t e;
        b = bps_of(i); h = b / 2; n = db_of(i); p = par_of(i); s = sb_of(i);
        dm = d & 9'((1 << n) - 1);
        bits[0] = 1'b0;
        nb = 1;
        for (int k = 0; k < n; k++) begin
            bits[nb] = dm[k];
            nb++;
        end
        if (p != 0) begin
            bits[nb] = ((($countones(dm) % 2) == 1) == (p == 2)) ^ flip_par;
            nb++;
        end
        for (int k = 0; k < s; k++) begin
            bits[nb] = ~stop0;
            nb++;
        end
        fall = 0;
        for (int idx = 0; idx < nb; idx++) begin
            len = (idx == nb - 1 && last_len > 0) ? last_len : b;
            for (int j = 0; j < len; j++) begin
                @(posedge sys_clk); #1;
                rxd[i] = (spike_bit >= 0 && idx == spike_bit + 1 && j == h + 1) ? 1'b1 : bits[idx];
                if (idx == 0 && j == 0) begin
                    fall = cyc;
                    if (expect_done) begin
                        e.due  = fall + (n + ((p != 0) ? 1 : 0) + s) * b + h + 4;
                        e.data = dm;
                        e.pe   = (p != 0) && flip_par;
                        e.fe   = stop0;
                        expq[i].push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Monitor: strobes must match the recorded frames in order and timing;
    // between strobes the outputs must hold the last delivered values.
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            for (int i = 0; i < NI; i++) begin
                if (!sys_rst_n) begin
                    expq[i].delete();
                    last_data[i] = '0;
                    last_pe[i]   = 1'b0;
                    last_fe[i]   = 1'b0;
                    chk("reset_outputs", i, int'({done[i], busy[i], perr[i], ferr[i], dat[i]}), 0);
                end else if (done[i]) begin
                    if (expq[i].size() == 0) begin
                        total++; bad++;
                        $display("FAIL spurious_done inst=%0d cyc=%0d got data=%0h want no strobe", i, cyc, dat[i]);
                    end else begin
                        e = expq[i].pop_front();
                        total++;
                        if (cyc < e.due - 1 || cyc > e.due + 1) begin
                            bad++;
                            $display("FAIL done_latency inst=%0d got cyc=%0d want cyc=%0d (+-1)", i, cyc, e.due);
                        end
                        chk("done_data", i, int'(dat[i]), int'(e.data));
                        chk("done_parity_err", i, int'(perr[i]), int'(e.pe));
                        chk("done_frame_err", i, int'(ferr[i]), int'(e.fe));
                        last_data[i] = e.data;
                        last_pe[i]   = e.pe;
                        last_fe[i]   = e.fe;
                        done_cnt[i]  = done_cnt[i] + 1;
                        done_cyc[i]  = cyc;
                    end
                end else begin
                    if (expq[i].size() != 0 && cyc > expq[i][0].due + 1) begin
                        total++; bad++;
                        $display("FAIL missing_done inst=%0d cyc=%0d got no strobe want strobe by cyc=%0d",
                                 i, cyc, expq[i][0].due + 1);
                        e = expq[i].pop_front();
                    end
                    chk("hold_outputs", i, int'({perr[i], ferr[i], dat[i]}),
                        int'({last_pe[i], last_fe[i], last_data[i]}));
                end
            end
        end
    end

    initial begin
        repeat (90000) @(posedge sys_clk);
        $display("FAIL watchdog cyc=%0d got no end want end of sequence", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f, f2, n0;
        for (int i = 0; i < NI; i++) begin
            rxd[i] = 1'b1;
            done_cnt[i] = 0;
            done_cyc[i] = 0;
        end
        sys_rst_n = 1'b0;
        idle(5);
        chk("reset_state", 0, int'({done, busy, perr, ferr}), 0);
        sys_rst_n = 1'b1;
        idle(20);

        // 8N1 0xA5: 9*234 + 117 + 4 = 2227 cycles to the strobe
        n0 = done_cnt[0];
        send_frame(0, 9'h0A5, 0, 0, 0, -1, 1, f);
        idle(10);
        chk("a5_count", 0, done_cnt[0] - n0, 1);
        chk("a5_data", 0, int'(data_a), 'hA5);
        chk("a5_errs", 0, int'({perr[0], ferr[0]}), 0);
        chk("a5_latency", 0, int'((done_cyc[0] - f) >= 2226 && (done_cyc[0] - f) <= 2228), 1);

        // 7E2 0x41: good parity, then flipped parity bit
        send_frame(1, 9'h041, 0, 0, 0, -1, 1, f);
        idle(10);
        chk("7e2_good_data", 1, int'(data_b), 'h41);
        chk("7e2_good_perr", 1, int'(perr[1]), 0);
        chk("7e2_latency", 1, int'((done_cyc[1] - f) >= 2460 && (done_cyc[1] - f) <= 2462), 1);
        send_frame(1, 9'h041, 1, 0, 0, -1, 1, f);
        idle(10);
        chk("7e2_bad_data", 1, int'(data_b), 'h41);
        chk("7e2_bad_perr", 1, int'(perr[1]), 1);
        chk("7e2_bad_ferr", 1, int'(ferr[1]), 0);

        // 8N1 0x3C with a low stop bit, line kept low for 3 more bit times
        n0 = done_cnt[0];
        send_frame(0, 9'h03C, 0, 1, 0, -1, 1, f);
        idle(3 * 234);
        chk("ferr_count", 0, done_cnt[0] - n0, 1);
        chk("ferr_flag", 0, int'(ferr[0]), 1);
        chk("ferr_data", 0, int'(data_a), 'h3C);
        chk("ferr_not_busy", 0, int'(busy[0]), 0);
        rxd[0] = 1'b1;
        idle(234);
        chk("ferr_no_restrobe", 0, done_cnt[0] - n0, 1);
        send_frame(0, 9'h096, 0, 0, 0, -1, 1, f);
        idle(10);
        chk("after_ferr_data", 0, int'(data_a), 'h96);
        chk("after_ferr_flag", 0, int'(ferr[0]), 0);

        // reset during data bit 4 of a frame, then a clean 0x5A
        n0 = done_cnt[0];
        fork
            send_frame(0, 9'h0F3, 0, 0, 0, -1, 0, f2);
            begin
                repeat (5 * 234 + 117) @(posedge sys_clk);
                #2;
                chk("pre_rst_busy", 0, int'(busy[0]), 1);
                chk("pre_rst_perr_b", 1, int'(perr[1]), 1);
                sys_rst_n = 1'b0;
                #1;
                chk("rst_busy", 0, int'(busy[0]), 0);
                chk("rst_data", 0, int'(data_a), 0);
                chk("rst_perr_b", 1, int'(perr[1]), 0);
                chk("rst_done", 0, int'(done), 0);
                repeat (3) @(posedge sys_clk);
                #2;
                sys_rst_n = 1'b1;
            end
        join
        idle(20);
        chk("rst_no_strobe", 0, done_cnt[0] - n0, 0);
        send_frame(0, 9'h05A, 0, 0, 0, -1, 1, f);
        idle(10);
        chk("post_rst_data", 0, int'(data_a), 'h5A);
        chk("post_rst_count", 0, done_cnt[0] - n0, 1);

        // 120-cycle glitch at 9600 baud (HALF = 1406): false start
        n0 = done_cnt[3];
        @(posedge sys_clk); #1;
        rxd[3] = 1'b0;
        for (int j = 1; j <= 1406 + 8; j++) begin
            @(posedge sys_clk); #1;
            if (j == 120) rxd[3] = 1'b1;
            if (j == 10) chk("glitch_busy_early", 3, int'(busy[3]), 1);
            if (j == 1406 + 1) chk("glitch_busy_mid", 3, int'(busy[3]), 1);
            if (j == 1406 + 7) chk("glitch_busy_end", 3, int'(busy[3]), 0);
        end
        idle(3000);
        chk("glitch_no_strobe", 3, done_cnt[3] - n0, 0);

        // 0x00 with a one-cycle spike in the centre of data bit 3
        n0 = done_cnt[0];
        send_frame(0, 9'h000, 0, 0, 0, 3, 1, f);
        idle(10);
        chk("spike_count", 0, done_cnt[0] - n0, 1);
        chk("spike_data", 0, int'(data_a), 0);

        // 9O1 back-to-back: next start edge 0.6 bit after the stop centre
        n0 = done_cnt[2];
        send_frame(2, 9'h1FF, 0, 0, 117 + 140, -1, 1, f);
        chk("b2b_first_data", 2, int'(data_c), 'h1FF);
        chk("b2b_first_latency", 2, int'((done_cyc[2] - f) >= 2694 && (done_cyc[2] - f) <= 2696), 1);
        send_frame(2, 9'h000, 0, 0, 0, -1, 1, f);
        idle(10);
        chk("b2b_count", 2, done_cnt[2] - n0, 2);
        chk("b2b_second_data", 2, int'(data_c), 0);
        chk("b2b_errs", 2, int'({perr[2], ferr[2]}), 0);

        idle(50);
        for (int i = 0; i < NI; i++)
            chk("queue_drained", i, expq[i].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
